// File: rtl/instruction_fetch_responder_if.sv
// Fetch request/response and store-load signals between a fetch unit and
// the instruction fetch responder.
interface instruction_fetch_responder_if #(
  parameter int DEPTH_LOG2 = 8
);
  logic                  req_valid;
  logic                  req_ready;
  logic [63:0]           req_addr;
  logic                  resp_valid;
  logic                  resp_ready;
  logic [31:0]           resp_data;
  logic [63:0]           resp_addr;
  logic                  resp_error;
  logic                  load_en;
  logic [DEPTH_LOG2-1:0] load_addr;
  logic [31:0]           load_data;

  modport master (
    output req_valid, req_addr, resp_ready, load_en, load_addr, load_data,
    input  req_ready, resp_valid, resp_data, resp_addr, resp_error
  );

  modport slave (
    input  req_valid, req_addr, resp_ready, load_en, load_addr, load_data,
    output req_ready, resp_valid, resp_data, resp_addr, resp_error
  );
endinterface

// File: rtl/instruction_fetch_responder.sv
// Instruction fetch responder: word store, one-entry read stage and a
// 3-entry in-order response FIFO with flush and async reset.
module instruction_fetch_responder #(
  parameter int DEPTH_LOG2 = 8
) (
  input logic                          clock,
  input logic                          reset,
  input logic                          flush,
  instruction_fetch_responder_if.slave bus
);
  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [31:0]           store_r [DEPTH];
  logic                  rs_valid_r;
  logic [63:0]           rs_addr_r;
  logic                  rs_error_r;
  logic [DEPTH_LOG2-1:0] rs_idx_r;
  logic [31:0]           fifo_data_r  [3];
  logic [63:0]           fifo_addr_r  [3];
  logic                  fifo_error_r [3];
  logic [1:0]            head_r;
  logic [1:0]            tail_r;
  logic [1:0]            count_r;

  logic [2:0]  occupancy_s;
  logic        req_ready_s;
  logic        accept_s;
  logic        resp_valid_s;
  logic        push_s;
  logic        pop_s;
  logic [31:0] rs_data_s;

  function automatic logic fetch_error(input logic [63:0] addr);
    return (addr[1:0] != 2'b00) || (|addr[63:DEPTH_LOG2+2]);
  endfunction

  function automatic logic [1:0] next_ptr(input logic [1:0] ptr);
    return (ptr == 2'd2) ? 2'd0 : ptr + 2'd1;
  endfunction

  // Handshake and datapath decode from registered state, flush and reset only
  always_comb begin
    occupancy_s  = {1'b0, count_r} + {2'b00, rs_valid_r};
    req_ready_s  = reset && !flush && (occupancy_s < 3'd3);
    accept_s     = bus.req_valid && req_ready_s;
    resp_valid_s = (count_r != 2'd0);
    push_s       = rs_valid_r && !flush;
    pop_s        = resp_valid_s && bus.resp_ready && !flush;
    rs_data_s    = 32'd0;
    if (!rs_error_r) begin
      rs_data_s = store_r[rs_idx_r];
    end else begin
      rs_data_s = 32'd0;
    end
  end

  // Store is deliberately left uncleared by reset
  always_ff @(posedge clock) begin
    if (bus.load_en) begin
      store_r[bus.load_addr] <= bus.load_data;
    end
  end

  // Read stage: holds one accepted request for the store lookup cycle
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rs_valid_r <= 1'b0;
      rs_addr_r  <= 64'd0;
      rs_error_r <= 1'b0;
      rs_idx_r   <= '0;
    end else if (flush) begin
      rs_valid_r <= 1'b0;
    end else begin
      rs_valid_r <= accept_s;
      if (accept_s) begin
        rs_addr_r  <= bus.req_addr;
        rs_error_r <= fetch_error(bus.req_addr);
        rs_idx_r   <= bus.req_addr[DEPTH_LOG2+1:2];
      end
    end
  end

  // Response FIFO; the old store word is captured even when a load hits it
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      head_r  <= 2'd0;
      tail_r  <= 2'd0;
      count_r <= 2'd0;
      for (int i = 0; i < 3; i++) begin
        fifo_data_r[i]  <= 32'd0;
        fifo_addr_r[i]  <= 64'd0;
        fifo_error_r[i] <= 1'b0;
      end
    end else if (flush) begin
      head_r  <= 2'd0;
      tail_r  <= 2'd0;
      count_r <= 2'd0;
    end else begin
      if (push_s) begin
        fifo_data_r[tail_r]  <= rs_data_s;
        fifo_addr_r[tail_r]  <= rs_addr_r;
        fifo_error_r[tail_r] <= rs_error_r;
        tail_r               <= next_ptr(tail_r);
      end
      if (pop_s) begin
        head_r <= next_ptr(head_r);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + 2'd1;
        2'b01:   count_r <= count_r - 2'd1;
        default: count_r <= count_r;
      endcase
    end
  end

  // Response outputs are zero whenever the FIFO head is not valid
  always_comb begin
    bus.req_ready  = req_ready_s;
    bus.resp_valid = resp_valid_s;
    bus.resp_data  = 32'd0;
    bus.resp_addr  = 64'd0;
    bus.resp_error = 1'b0;
    if (resp_valid_s) begin
      bus.resp_data  = fifo_data_r[head_r];
      bus.resp_addr  = fifo_addr_r[head_r];
      bus.resp_error = fifo_error_r[head_r];
    end else begin
      bus.resp_data  = 32'd0;
      bus.resp_addr  = 64'd0;
      bus.resp_error = 1'b0;
    end
  end
endmodule

// File: tb/tb_instruction_fetch_responder.sv
// Directed bench for instruction_fetch_responder with hand-computed expectations.
module tb_instruction_fetch_responder;
  logic clock = 1'b0;
  logic reset = 1'b0;
  logic flush = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clock = ~clock;

  instruction_fetch_responder_if #(.DEPTH_LOG2(8)) bus ();

  instruction_fetch_responder #(.DEPTH_LOG2(8)) dut (
    .clock (clock),
    .reset (reset),
    .flush (flush),
    .bus   (bus)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    bus.req_valid = 1'b0; bus.req_addr = 64'd0; bus.resp_ready = 1'b0;
    bus.load_en = 1'b0; bus.load_addr = 8'd0; bus.load_data = 32'd0;
    #2;
    n_cmp++; if (bus.resp_valid !== 1'b0) begin n_bad++; $display("FAIL reset_resp_valid: got %b want 0", bus.resp_valid); end
    n_cmp++; if (bus.req_ready !== 1'b0) begin n_bad++; $display("FAIL reset_req_ready: got %b want 0", bus.req_ready); end
    n_cmp++; if (bus.resp_data !== 32'd0) begin n_bad++; $display("FAIL reset_resp_data: got %h want 0", bus.resp_data); end
    n_cmp++; if (bus.resp_addr !== 64'd0) begin n_bad++; $display("FAIL reset_resp_addr: got %h want 0", bus.resp_addr); end
    tick(); tick();
    #2 reset = 1'b1;
    #1;
    n_cmp++; if (bus.req_ready !== 1'b1) begin n_bad++; $display("FAIL reset_release_ready: got %b want 1", bus.req_ready); end
    tick();
  endtask

  task automatic test_basic_stream();
    for (int i = 0; i < 4; i++) begin
      bus.load_en = 1'b1; bus.load_addr = 8'(i); bus.load_data = 32'h11 * (i + 1);
      tick();
    end
    bus.load_en = 1'b1; bus.load_addr = 8'd5; bus.load_data = 32'h55;
    tick();
    bus.load_en = 1'b0;
    bus.resp_ready = 1'b1;
    for (int w = 0; w < 8; w++) begin
      bus.req_valid = (w < 4);
      bus.req_addr  = 64'(4 * w);
      #1;
      if (w < 4) begin
        n_cmp++; if (bus.req_ready !== 1'b1) begin n_bad++; $display("FAIL stream_ready w%0d: got %b want 1", w, bus.req_ready); end
      end
      n_cmp++; if (bus.resp_valid !== (w >= 2 && w <= 5)) begin n_bad++; $display("FAIL stream_valid w%0d: got %b", w, bus.resp_valid); end
      if (w >= 2 && w <= 5) begin
        n_cmp++; if (bus.resp_data !== 32'h11 * (w - 1)) begin n_bad++; $display("FAIL stream_data w%0d: got %h want %h", w, bus.resp_data, 32'h11 * (w - 1)); end
        n_cmp++; if (bus.resp_addr !== 64'(4 * (w - 2))) begin n_bad++; $display("FAIL stream_addr w%0d: got %h want %h", w, bus.resp_addr, 4 * (w - 2)); end
        n_cmp++; if (bus.resp_error !== 1'b0) begin n_bad++; $display("FAIL stream_error w%0d: got %b want 0", w, bus.resp_error); end
      end
      tick();
    end
    bus.req_valid = 1'b0;
  endtask

  task automatic test_backpressure();
    logic [63:0] addr_next;
    int          accepts;
    int          k;
    logic [31:0] exp_data [3];
    exp_data[0] = 32'h11; exp_data[1] = 32'h22; exp_data[2] = 32'h33;
    addr_next = 64'd0; accepts = 0; k = 0;
    bus.resp_ready = 1'b0;
    for (int w = 0; w < 6; w++) begin
      bus.req_valid = 1'b1; bus.req_addr = addr_next;
      #1;
      n_cmp++; if (bus.req_ready !== (w < 3)) begin n_bad++; $display("FAIL bp_ready w%0d: got %b", w, bus.req_ready); end
      if (bus.req_ready) begin accepts++; addr_next = addr_next + 64'd4; end
      if (w >= 2) begin
        n_cmp++; if (bus.resp_data !== 32'h11 || bus.resp_addr !== 64'd0) begin n_bad++; $display("FAIL bp_head_stable w%0d: got %h/%h want 11/0", w, bus.resp_data, bus.resp_addr); end
      end
      tick();
    end
    n_cmp++; if (accepts !== 3) begin n_bad++; $display("FAIL bp_accepts: got %0d want 3", accepts); end
    bus.req_valid = 1'b0; bus.resp_ready = 1'b1;
    for (int w = 0; w < 10; w++) begin
      #1;
      if (bus.resp_valid) begin
        n_cmp++;
        if (k >= 3) begin n_bad++; $display("FAIL bp_extra_resp: got %h want none", bus.resp_data); end
        else if (bus.resp_data !== exp_data[k]) begin n_bad++; $display("FAIL bp_drain_order %0d: got %h want %h", k, bus.resp_data, exp_data[k]); end
        k++;
      end
      tick();
    end
    n_cmp++; if (k !== 3) begin n_bad++; $display("FAIL bp_drain_count: got %0d want 3", k); end
    n_cmp++; if (bus.req_ready !== 1'b1) begin n_bad++; $display("FAIL bp_ready_return: got %b want 1", bus.req_ready); end
  endtask

  task automatic test_error();
    logic [63:0] bad_addr [2];
    bad_addr[0] = 64'h6; bad_addr[1] = 64'h400;
    bus.resp_ready = 1'b1;
    for (int t = 0; t < 2; t++) begin
      bus.req_valid = 1'b1; bus.req_addr = bad_addr[t];
      tick();
      bus.req_valid = 1'b0;
      tick();
      #1;
      n_cmp++; if (bus.resp_valid !== 1'b1) begin n_bad++; $display("FAIL err_valid %h: got %b want 1", bad_addr[t], bus.resp_valid); end
      n_cmp++; if (bus.resp_error !== 1'b1) begin n_bad++; $display("FAIL err_flag %h: got %b want 1", bad_addr[t], bus.resp_error); end
      n_cmp++; if (bus.resp_data !== 32'd0) begin n_bad++; $display("FAIL err_data %h: got %h want 0", bad_addr[t], bus.resp_data); end
      n_cmp++; if (bus.resp_addr !== bad_addr[t]) begin n_bad++; $display("FAIL err_addr: got %h want %h", bus.resp_addr, bad_addr[t]); end
      tick();
    end
  endtask

  task automatic test_flush();
    bus.resp_ready = 1'b0;
    for (int w = 0; w < 3; w++) begin
      bus.req_valid = 1'b1; bus.req_addr = 64'(4 * w);
      tick();
    end
    flush = 1'b1; bus.req_addr = 64'hC;
    #1;
    n_cmp++; if (bus.req_ready !== 1'b0) begin n_bad++; $display("FAIL flush_no_accept: got %b want 0", bus.req_ready); end
    tick();
    flush = 1'b0; bus.req_valid = 1'b0;
    #1;
    n_cmp++; if (bus.resp_valid !== 1'b0) begin n_bad++; $display("FAIL flush_valid_next: got %b want 0", bus.resp_valid); end
    bus.resp_ready = 1'b1;
    for (int w = 0; w < 4; w++) begin
      tick();
      n_cmp++; if (bus.resp_valid !== 1'b0) begin n_bad++; $display("FAIL flush_stale w%0d: got %b/%h want 0", w, bus.resp_valid, bus.resp_data); end
    end
    bus.req_valid = 1'b1; bus.req_addr = 64'hC;
    tick();
    bus.req_valid = 1'b0;
    tick();
    #1;
    n_cmp++; if (bus.resp_valid !== 1'b1 || bus.resp_data !== 32'h44) begin n_bad++; $display("FAIL flush_after: got %b/%h want 1/44", bus.resp_valid, bus.resp_data); end
    tick();
  endtask

  task automatic test_load_collision();
    bus.resp_ready = 1'b1;
    bus.req_valid = 1'b1; bus.req_addr = 64'h14;
    tick();
    bus.req_valid = 1'b0;
    bus.load_en = 1'b1; bus.load_addr = 8'd5; bus.load_data = 32'hAA;
    tick();
    bus.load_en = 1'b0;
    bus.req_valid = 1'b1; bus.req_addr = 64'h14;
    #1;
    n_cmp++; if (bus.resp_valid !== 1'b1 || bus.resp_data !== 32'h55) begin n_bad++; $display("FAIL collide_old: got %b/%h want 1/55", bus.resp_valid, bus.resp_data); end
    tick();
    bus.req_valid = 1'b0;
    tick();
    #1;
    n_cmp++; if (bus.resp_valid !== 1'b1 || bus.resp_data !== 32'hAA) begin n_bad++; $display("FAIL collide_new: got %b/%h want 1/aa", bus.resp_valid, bus.resp_data); end
    tick();
  endtask

  task automatic test_reset_midflight();
    bus.resp_ready = 1'b1;
    bus.req_valid = 1'b1; bus.req_addr = 64'h8;
    tick();
    bus.req_valid = 1'b0;
    #2 reset = 1'b0;
    #1;
    n_cmp++; if (bus.resp_valid !== 1'b0 || bus.req_ready !== 1'b0) begin n_bad++; $display("FAIL midreset_outputs: got valid %b ready %b want 0/0", bus.resp_valid, bus.req_ready); end
    n_cmp++; if (bus.resp_data !== 32'd0 || bus.resp_addr !== 64'd0 || bus.resp_error !== 1'b0) begin n_bad++; $display("FAIL midreset_zero: got %h/%h/%b want 0", bus.resp_data, bus.resp_addr, bus.resp_error); end
    tick();
    #2 reset = 1'b1;
    #1;
    n_cmp++; if (bus.req_ready !== 1'b1) begin n_bad++; $display("FAIL midreset_release_ready: got %b want 1", bus.req_ready); end
    for (int w = 0; w < 4; w++) begin
      tick();
      n_cmp++; if (bus.resp_valid !== 1'b0) begin n_bad++; $display("FAIL midreset_ghost w%0d: got %b/%h want 0", w, bus.resp_valid, bus.resp_data); end
    end
    bus.req_valid = 1'b1; bus.req_addr = 64'h8;
    tick();
    bus.req_valid = 1'b0;
    tick();
    #1;
    n_cmp++; if (bus.resp_valid !== 1'b1 || bus.resp_data !== 32'h33) begin n_bad++; $display("FAIL midreset_store_kept: got %b/%h want 1/33", bus.resp_valid, bus.resp_data); end
    tick();
  endtask

  initial begin
    test_reset();
    test_basic_stream();
    test_backpressure();
    test_error();
    test_flush();
    test_load_collision();
    test_reset_midflight();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/instruction_fetch_responder.md
INSTRUCTION_FETCH_RESPONDER -- requirements
Module: instruction_fetch_responder

Interface
REQ-001 SHALL have parameter DEPTH_LOG2, default 8, meaning log2 of the instruction-word store depth (256 x 32-bit words).
REQ-002 SHALL have port clock  input  1  single clock; all state updates on posedge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-004 SHALL have port flush  input  1  synchronous discard of in-flight and buffered responses.
REQ-005 SHALL have port req_valid  input  1  fetch request present.
REQ-006 SHALL have port req_ready  output  1  responder accepts request this cycle.
REQ-007 SHALL have port req_addr  input  64  byte address of requested instruction (PC).
REQ-008 SHALL have port resp_valid  output  1  response at FIFO head.
REQ-009 SHALL have port resp_ready  input  1  consumer takes response this cycle.
REQ-010 SHALL have port resp_data  output  32  instruction word.
REQ-011 SHALL have port resp_addr  output  64  echo of req_addr for this response.
REQ-012 SHALL have port resp_error  output  1  misaligned or out-of-range fetch.
REQ-013 SHALL have port load_en  input  1  store write enable.
REQ-014 SHALL have port load_addr  input  DEPTH_LOG2  word index to write.
REQ-015 SHALL have port load_data  input  32  word to write.

Function
REQ-016 SHALL accept a request on a posedge where req_valid && req_ready; occupancy = in-flight read-stage entries + response-FIFO entries.
REQ-017 SHALL drive req_ready = (occupancy < 3) && !flush, computed from registered state and flush only, with no path from resp_ready.
REQ-018 SHALL hold an accepted request in a one-entry read stage for one cycle, then push {data, addr, error} into a 3-entry response FIFO; resp_valid SHALL first be high in the 2nd cycle after the accepting edge (latency 2).
REQ-019 SHALL sustain one accepted request per cycle when resp_ready is held at 1.
REQ-020 SHALL flag resp_error=1 with resp_data=32'd0 when req_addr[1:0] != 0, or when req_addr[63:2] >= 2**DEPTH_LOG2; otherwise resp_data = store[req_addr[DEPTH_LOG2+1:2]], resp_error=0.
REQ-021 SHALL pop the FIFO head on a posedge where resp_valid && resp_ready; a push and a pop on the same edge SHALL leave the count unchanged.
REQ-022 SHALL hold resp_data, resp_addr and resp_error stable while resp_valid && !resp_ready.
REQ-023 SHALL return responses strictly in request order.
REQ-024 SHALL write load_data to store[load_addr] on posedge when load_en=1; a read-stage read of the same index in that cycle SHALL return the old word.
REQ-025 SHALL, on posedge with flush=1, empty the FIFO and read stage, accept no request, and push nothing; resp_valid SHALL be 0 in the next cycle.
REQ-026 SHALL drive resp_data=0, resp_addr=0, resp_error=0 whenever resp_valid=0.

Reset
REQ-027 SHALL, while reset=0, asynchronously clear the read stage and FIFO pointers/count, force resp_valid=0, resp_data=0, resp_addr=0, resp_error=0, req_ready=0.
REQ-028 SHALL NOT clear the instruction store on reset.
REQ-029 SHALL drive req_ready=1 in the first cycle after reset deasserts (with flush=0).
REQ-030 SHALL discard any in-flight request when reset asserts mid-operation; no response for it SHALL appear after release.

Verification
REQ-031 SHALL cover: load store[0..3]=32'h11,22,33,44; requests 0x0,0x4,0x8,0xC back-to-back, resp_ready=1 -> 4 responses, data 11,22,33,44, first resp_valid 2 cycles after first accept, one per cycle thereafter.
REQ-032 SHALL cover: resp_ready=0, req_valid=1 continuously -> exactly 3 accepts, then req_ready=0; head data/addr stable; raise resp_ready -> remaining responses drain in order, req_ready returns to 1.
REQ-033 SHALL cover: req_addr=0x6 -> resp_error=1, resp_data=0, resp_addr=0x6; req_addr=0x400 (DEPTH_LOG2=8) -> resp_error=1, resp_data=0.
REQ-034 SHALL cover: 2 buffered + 1 in-flight, flush=1 with req_valid=1 for one cycle -> no accept that cycle, resp_valid=0 next cycle, no stale responses afterwards.
REQ-035 SHALL cover: load_en to index 5 with data 32'hAA in the same cycle index 5 is in the read stage (old 32'h55) -> response 32'h55; next fetch of 0x14 -> 32'hAA.
REQ-036 SHALL cover: reset=0 asserted between clock edges with one request in flight -> outputs zero immediately; after release, resp_valid stays 0 until a new request, and store contents are preserved.
